// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count_monitor checker and its FIFO.
package count_monitor_pkg;

    // Checker state: IDLE until a baseline sample has been taken.
    typedef enum logic {
        StIdle,
        StTrack
    } state_e;

    // Check result attached to each sample: {skip, repeat}.
    typedef logic [1:0] tag_t;

    localparam tag_t TAG_OK     = 2'b00;
    localparam tag_t TAG_REPEAT = 2'b01;
    localparam tag_t TAG_SKIP   = 2'b10;

    // Error counter width and its saturation value.
    localparam int unsigned ErrCntWidth = 8;
    localparam logic [ErrCntWidth-1:0] ErrCntMax = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy and full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic [$clog2(Depth):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LvlFull);
    assign empty_o = (level_q == '0);

    // Pop needs a stored entry, so an empty FIFO cannot fall through.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next pointer and occupancy values; pointers wrap since Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LvlW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Head entry is forced to zero while empty so outputs read 0 in reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/count_monitor.sv
// Reader-side counter monitor: registers each published count, checks it is
// the previous value plus one, and queues {tag, count} for a downstream reader.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    input  logic [WIDTH-1:0]       wr_count,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_count,
    output tag_t                   rd_tag,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_skip,
    output logic                   err_repeat,
    output logic                   overflow,
    output logic [ErrCntWidth-1:0] err_count,
    input  logic                   clear_err
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic                   err_skip_q, err_skip_d;
    logic                   err_repeat_q, err_repeat_d;
    logic                   overflow_q, overflow_d;
    logic [ErrCntWidth-1:0] err_count_q, err_count_d;

    tag_t             tag;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH+1:0] fifo_rdata;

    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;
    assign drop     = wr_valid && fifo_full && !pop;

    // Classify the incoming sample against the expected value (modulo 2^WIDTH).
    always_comb begin
        tag = TAG_OK;
        if (state_q == StTrack) begin
            if (wr_count == expected_q) begin
                tag = TAG_OK;
            end else if (wr_count == expected_q - One) begin
                tag = TAG_REPEAT;
            end else begin
                tag = TAG_SKIP;
            end
        end
    end

    // Next checker state and sticky flags; a set in the clearing cycle wins.
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        err_skip_d   = clear_err ? 1'b0 : err_skip_q;
        err_repeat_d = clear_err ? 1'b0 : err_repeat_q;
        overflow_d   = clear_err ? 1'b0 : overflow_q;
        err_count_d  = clear_err ? '0 : err_count_q;
        if (wr_valid) begin
            // Resynchronise on every sample, including dropped ones.
            state_d    = StTrack;
            expected_d = wr_count + One;
            if (tag == TAG_SKIP) begin
                err_skip_d = 1'b1;
            end
            if (tag == TAG_REPEAT) begin
                err_repeat_d = 1'b1;
            end
            if (tag != TAG_OK && err_count_d != ErrCntMax) begin
                err_count_d = err_count_d + ErrCntWidth'(1);
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Checker state and error registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            expected_q   <= '0;
            err_skip_q   <= 1'b0;
            err_repeat_q <= 1'b0;
            overflow_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            err_skip_q   <= err_skip_d;
            err_repeat_q <= err_repeat_d;
            overflow_q   <= overflow_d;
            err_count_q  <= err_count_d;
        end
    end

    sync_fifo #(
        .Width (WIDTH + 2),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (wr_valid),
        .data_i  ({tag, wr_count}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_count   = fifo_rdata[WIDTH-1:0];
    assign rd_tag     = fifo_rdata[WIDTH+:2];
    assign err_skip   = err_skip_q;
    assign err_repeat = err_repeat_q;
    assign overflow   = overflow_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor at WIDTH=8, DEPTH=4.
module tb_count_monitor;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic [W-1:0] wr_count = '0;
    logic         rd_ready = 1'b0;
    logic         clear_err = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_count;
    logic [1:0]   rd_tag;
    logic [2:0]   level;
    logic         err_skip;
    logic         err_repeat;
    logic         overflow;
    logic [7:0]   err_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    count_monitor #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_count   (wr_count),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_count   (rd_count),
        .rd_tag     (rd_tag),
        .level      (level),
        .err_skip   (err_skip),
        .err_repeat (err_repeat),
        .overflow   (overflow),
        .err_count  (err_count),
        .clear_err  (clear_err)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [W-1:0] c, input logic rdy, input logic clr);
        wr_valid  = v;
        wr_count  = c;
        rd_ready  = rdy;
        clear_err = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        clear_err = 1'b0;
        reset_n   = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_flags(input string name, input logic s, input logic r, input logic o,
                             input logic [7:0] n);
        chk({name, "_skip"}, 32'(err_skip), 32'(s));
        chk({name, "_repeat"}, 32'(err_repeat), 32'(r));
        chk({name, "_ovf"}, 32'(overflow), 32'(o));
        chk({name, "_errcnt"}, 32'(err_count), 32'(n));
    endtask

    task automatic chk_head(input string name, input logic [7:0] c, input logic [1:0] t);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_count"}, 32'(rd_count), 32'(c));
        chk({name, "_tag"}, 32'(rd_tag), 32'(t));
    endtask

    initial begin
        logic [7:0] inorder [4];
        logic [7:0] rs_val [4];
        logic [1:0] rs_tag [4];
        inorder = '{8'd5, 8'd6, 8'd7, 8'd8};
        rs_val  = '{8'd10, 8'd10, 8'd12, 8'd13};
        rs_tag  = '{2'b00, 2'b01, 2'b10, 2'b00};

        // Reset values
        #3;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(rd_count), 32'd0);
        chk("rst_tag", 32'(rd_tag), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // In-order stream, one-cycle latency, streaming reads
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, inorder[i], 1'b1, 1'b0);
            chk_head("inorder", inorder[i], 2'b00);
            chk("inorder_level", 32'(level), 32'd1);
        end
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("inorder_drained", 32'(rd_valid), 32'd0);
        chk_flags("inorder", 1'b0, 1'b0, 1'b0, 8'd0);

        // Repeat and skip
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, rs_val[i], 1'b1, 1'b0);
            chk_head("rs", rs_val[i], rs_tag[i]);
        end
        chk_flags("rs", 1'b1, 1'b1, 1'b0, 8'd2);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // Wrap-around at WIDTH=8
        do_reset();
        cyc(1'b1, 8'd254, 1'b1, 1'b0);
        chk_head("wrap254", 8'd254, 2'b00);
        cyc(1'b1, 8'd255, 1'b1, 1'b0);
        chk_head("wrap255", 8'd255, 2'b00);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        chk_head("wrap0", 8'd0, 2'b00);
        cyc(1'b1, 8'd1, 1'b1, 1'b0);
        chk_head("wrap1", 8'd1, 2'b00);
        chk_flags("wrap", 1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 8'd255, 1'b1, 1'b0);
        chk_head("wrap_skip255", 8'd255, 2'b10);
        cyc(1'b1, 8'd1, 1'b1, 1'b0);
        chk_head("wrap_skip1", 8'd1, 2'b10);
        chk_flags("wrapskip", 1'b1, 1'b0, 1'b0, 8'd2);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // FIFO boundary: fill, overflow, then push while full with a pop
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_level", 32'(level), (i < 4) ? 32'(i + 1) : 32'd4);
            chk("fill_ovf", 32'(overflow), (i < 4) ? 32'd0 : 32'd1);
        end
        chk_head("full_head", 8'd0, 2'b00);
        cyc(1'b1, 8'd6, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd4);
        chk_head("drain1", 8'd1, 2'b00);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk_head("drain2", 8'd2, 2'b00);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk_head("drain3", 8'd3, 2'b00);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk_head("drain6", 8'd6, 2'b00);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(rd_valid), 32'd0);
        chk_flags("fifo", 1'b0, 1'b0, 1'b1, 8'd0);

        // Clear colliding with a skip (expected is 7 here), then clear alone
        cyc(1'b1, 8'd20, 1'b1, 1'b1);
        chk_head("clr_skip", 8'd20, 2'b10);
        chk_flags("clr_collide", 1'b1, 1'b0, 1'b0, 8'd1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        chk_flags("clr_alone", 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset mid-operation with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(21 + i), 1'b0, 1'b0);
        end
        chk("mid_level", 32'(level), 32'd3);
        chk_flags("mid", 1'b0, 1'b0, 1'b0, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 8'd100, 1'b1, 1'b0);
        chk_head("baseline100", 8'd100, 2'b00);
        chk("baseline_level", 32'(level), 32'd1);
        chk_flags("baseline", 1'b0, 1'b0, 1'b0, 8'd0);

        // err_count saturation: 300 consecutive skips (steps of 3)
        do_reset();
        for (int i = 0; i <= 300; i++) begin
            cyc(1'b1, 8'(i * 3), 1'b1, 1'b0);
            if (i == 254) begin
                chk("sat_254", 32'(err_count), 32'd254);
            end
        end
        chk_flags("sat", 1'b1, 1'b0, 1'b0, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Reader-side endpoint for the counter update interface. It samples every count value the writer publishes on `wr_valid`/`wr_count`, registers it on the clock edge so the read/write race cannot occur, and checks that each value is exactly the previous value plus one. Each accepted sample goes into a small FIFO together with its check result, and a logger or scoreboard drains the FIFO through a valid/ready port.

## Interface
- `WIDTH`, 32: counter width in bits; must be at least 2.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `clock` input 1: single clock; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised upstream.
- `wr_valid` input 1: writer publishes a count this cycle.
- `wr_count` input WIDTH: published count value.
- `rd_valid` output 1: FIFO head entry is available.
- `rd_ready` input 1: consumer accepts the head entry.
- `rd_count` output WIDTH: count value of the head entry.
- `rd_tag` output 2: check result of the head entry: {skip, repeat}.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.
- `err_skip` output 1: sticky; a skip was detected.
- `err_repeat` output 1: sticky; a repeat was detected.
- `overflow` output 1: sticky; a sample was dropped because the FIFO was full.
- `err_count` output 8: saturating count of skip plus repeat events.
- `clear_err` input 1: synchronous clear of all sticky flags and of `err_count`.

## Operation
- **States.** The checker has two states, IDLE and TRACK. IDLE means no baseline sample has been taken yet.
- **IDLE.** On `wr_valid`, the sample becomes the baseline. It is pushed with tag 00, `expected` becomes `wr_count`+1, and the state moves to TRACK.
- **TRACK.** On `wr_valid`, the sample is checked and pushed:
  - `wr_count` == `expected`: tag 00.
  - `wr_count` == `expected`−1: tag 01 (repeat).
  - Any other value: tag 10 (skip).
  - In every case `expected` becomes `wr_count`+1, so the checker resynchronises after an error.
- **Arithmetic.** All count arithmetic is modulo 2^WIDTH. From all-ones, `expected` is 0, and a sample of 0 after all-ones is tagged 00.
- **Error flags.**
  - A repeat sets `err_repeat`; a skip sets `err_skip`.
  - Each error increments `err_count`, which saturates at 255.
  - When an error and `clear_err` occur in the same cycle, the set wins: the flag ends at 1 and `err_count` ends at 1.
- **Push/pop.**
  - A push happens on `wr_valid`. A pop happens when `rd_valid` and `rd_ready` are both high.
  - If the FIFO is full and no pop occurs that cycle, the sample is dropped and `overflow` is set. `expected` and the error flags still update from the dropped sample.
  - If the FIFO is full and a pop occurs that same cycle, the push is accepted and `level` stays at DEPTH.
  - If the FIFO is empty and a push occurs, `rd_valid` cannot fall through; no pop occurs that cycle.
- **Read port.** `rd_count` and `rd_tag` are don't-care while `rd_valid` is 0.

## Timing
- **Reset.** While `reset_n` is 0:
  - State is IDLE, `expected` is 0, and the FIFO pointers are 0.
  - `rd_valid`, `rd_count`, `rd_tag`, `level`, `err_skip`, `err_repeat`, `overflow` and `err_count` are all 0.
  - FIFO contents are not reset.
- **Reset mid-operation.** Stored entries are discarded and the next sample is treated as a new baseline.
- **Latency.** A sample accepted at edge N appears with `rd_valid`=1 in the cycle after edge N, i.e. one cycle of latency. `rd_count` and `rd_tag` are driven from registered FIFO state.
- **Read handshake.** Once `rd_valid` is high, `rd_count` and `rd_tag` stay stable until the pop edge. Back-to-back pops drain one entry per cycle.
- **Flag timing.** Sticky flags and `err_count` update at the same edge that samples the offending `wr_count`.
- **Throughput.** One sample per cycle in and one entry per cycle out, sustained.

## Structure
- **Package `count_monitor_pkg`** holds:
  - the state enum (IDLE, TRACK);
  - the tag typedef and named constants TAG_OK=00, TAG_REPEAT=01, TAG_SKIP=10;
  - the `err_count` width and saturation constant.
- **Sub-module `sync_fifo`**, parameterised by data width and DEPTH. It stores {tag, count}, has a show-ahead output, a registered `level`, and full/empty flags. The top level contains the checker, the flags and the counter.
- **Coding rule.** All state is written with nonblocking assignments in clocked processes; combinational next-value logic is kept separate.

## Test plan
- **In-order stream.** Reset, then `wr_count`=5,6,7,8 back-to-back with `rd_ready`=1 → read 5,6,7,8, all tag 00, one cycle after each write; no flags set.
- **Repeat and skip.** Write 10,10,12,13 → tags 00,01,10,00; `err_repeat`=1, `err_skip`=1, `err_count`=2.
- **Wrap-around.** With WIDTH=8, write 254,255,0,1 → all tags 00; writing 255 then 1 gives tag 10.
- **FIFO boundary.** With `rd_ready`=0 and DEPTH=4, write 0..5 → `level`=4, `overflow`=1, FIFO holds 0..3. Then write 6 with `rd_ready`=1 in the same cycle → accepted, `level` stays 4, and the subsequent reads are 1,2,3,6.
- **Clear collision.** Assert `clear_err` in the same cycle as a skip → `err_skip`=1, `err_count`=1. Assert `clear_err` alone → all flags 0.
- **Reset mid-operation.** Pulse `reset_n` low with 3 entries queued → `rd_valid`=0 and `level`=0 immediately. Then write 100 → 100 is read with tag 00 as the new baseline.
